// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the serially loaded instruction store.
// Optional readback is selected with the PROG_LOADER_READBACK_EN macro.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  localparam int DEF_DEPTH       = 16;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin with an optional
// one-cycle rising-edge pulse on the synchronized value.
module pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RISE_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign dout = sync[SYNC_STAGES-1];

  generate
    if (RISE_EN) begin : g_rise
      logic prev;
      always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= dout;
      end
      assign rise = dout & ~prev;
    end else begin : g_no_rise
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/prog_loader.sv
// 16 x 8 instruction store loaded over a three-pin serial link while the CPU
// is held in reset. Define PROG_LOADER_READBACK_EN to stream old words on ld_sdo.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic              ld_sclk,
  input  logic              ld_sdata,
  input  logic [ADDR_W-1:0] address,
  output logic [7:0]        instr,
  output logic              cpu_n_reset,
  output logic              ld_full,
  output logic              ld_sdo
);

  logic en_s, sclk_s, data_s, sclk_rise;
  logic unused_en_rise, unused_data_rise, unused_sclk_s;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_EN(1'b0)) u_sync_en (
    .clk(clk), .rst_n(rst_n), .din(ld_en), .dout(en_s), .rise(unused_en_rise)
  );
  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(ld_sclk), .dout(sclk_s), .rise(sclk_rise)
  );
  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_EN(1'b0)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .din(ld_sdata), .dout(data_s), .rise(unused_data_rise)
  );
  assign unused_sclk_s = sclk_s;

  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [2:0]          bit_cnt;
  logic [6:0]          shift;
  logic                shift_en, wr_fire;

  // A bit is accepted only while LOAD is still requested; exit takes priority.
  assign shift_en = (state == LOAD) && en_s && sclk_rise;
  assign wr_fire  = shift_en && (bit_cnt == 3'd7);

  // NOTE: the store is built from resettable flops rather than a RAM so that
  // a reset mid-load always leaves a known all-NOP program behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_INSTR;
    end else if (wr_fire) begin
      mem[wr_ptr] <= {shift, data_s};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      cpu_n_reset <= 1'b1;
      wr_ptr      <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      ld_full     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (en_s) begin
            state       <= LOAD;
            cpu_n_reset <= 1'b0;
            wr_ptr      <= '0;
            bit_cnt     <= '0;
            ld_full     <= 1'b0;
          end
        end
        LOAD: begin
          if (!en_s) begin
            state   <= RELEASE;
            bit_cnt <= '0;
          end else if (shift_en) begin
            shift   <= {shift[5:0], data_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (wr_fire) begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
              if (wr_ptr == ADDR_W'(DEPTH - 1)) ld_full <= 1'b1;
            end
          end
        end
        RELEASE: begin
          state       <= RUN;
          cpu_n_reset <= 1'b1;
        end
        default: begin
          state       <= RUN;
          cpu_n_reset <= 1'b1;
        end
      endcase
    end
  end

  assign instr = (state == RUN) ? mem[address] : NOP_INSTR;

`ifdef PROG_LOADER_READBACK_EN
  logic [7:0] tx_shift;

  // Preload the outgoing word between bytes so it leads the incoming one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift <= '0;
    end else if (state == LOAD) begin
      if (sclk_rise)           tx_shift <= {tx_shift[6:0], 1'b0};
      else if (bit_cnt == 3'd0) tx_shift <= mem[wr_ptr];
    end
  end

  assign ld_sdo = tx_shift[7];
`else
  assign ld_sdo = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; the readback expectations
// follow the PROG_LOADER_READBACK_EN macro.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_en = 1'b0;
  logic       ld_sclk = 1'b0;
  logic       ld_sdata = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] instr;
  logic       cpu_n_reset, ld_full, ld_sdo;

  int checks = 0;
  int failures = 0;

  prog_loader #(.DEPTH(16), .ADDR_W(4), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_sclk(ld_sclk),
    .ld_sdata(ld_sdata), .address(address), .instr(instr),
    .cpu_n_reset(cpu_n_reset), .ld_full(ld_full), .ld_sdo(ld_sdo)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_word(input logic [3:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = instr;
  endtask

  task automatic send_bit(input logic b, output logic sdo);
    ld_sdata = b;
    tick(1);
    sdo = ld_sdo;
    ld_sclk = 1'b1;
    tick(SYNC + 3);
    ld_sclk = 1'b0;
    tick(SYNC + 3);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic [7:0] sdo_bits);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], s);
      sdo_bits[i] = s;
    end
  endtask

  task automatic enter_load();
    ld_en = 1'b1;
    tick(SYNC + 3);
    checks++;
    if (cpu_n_reset !== 1'b0) begin
      failures++;
      $display("FAIL enter_load cpu_n_reset got=%b exp=0", cpu_n_reset);
    end
    checks++;
    if (instr !== 8'h00) begin
      failures++;
      $display("FAIL enter_load instr got=%h exp=00", instr);
    end
  endtask

  // Drop ld_en and measure how many edges pass until cpu_n_reset rises.
  task automatic exit_load();
    int n = 0;
    ld_en = 1'b0;
    while (cpu_n_reset !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != SYNC + 2) begin
      failures++;
      $display("FAIL exit_latency got=%0d exp=%0d", n, SYNC + 2);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (cpu_n_reset !== 1'b1 || ld_full !== 1'b0 || ld_sdo !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b exp=100", cpu_n_reset, ld_full, ld_sdo);
    end
    rst_n = 1'b1;
    tick(1);
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d);
      checks++;
      if (d !== 8'h00 || cpu_n_reset !== 1'b1 || ld_full !== 1'b0) begin
        failures++;
        $display("FAIL reset_sweep addr=%0d instr=%h rst=%b full=%b exp=00/1/0",
                 a, d, cpu_n_reset, ld_full);
      end
    end
  endtask

  task automatic test_full_load();
    logic [7:0] prog [16] = '{8'hB7, 8'h01, 8'hE1, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                              8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
    logic [7:0] d, sdo;
    enter_load();
    for (int i = 0; i < 16; i++) begin
      send_byte(prog[i], sdo);
      if (i == 14) begin
        checks++;
        if (ld_full !== 1'b0) begin
          failures++;
          $display("FAIL full_after_15 got=%b exp=0", ld_full);
        end
      end
    end
    checks++;
    if (ld_full !== 1'b1 || cpu_n_reset !== 1'b0) begin
      failures++;
      $display("FAIL full_after_16 full=%b rst=%b exp=1/0", ld_full, cpu_n_reset);
    end
    exit_load();
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d);
      checks++;
      if (d !== prog[a]) begin
        failures++;
        $display("FAIL full_word addr=%0d got=%h exp=%h", a, d, prog[a]);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [7:0] d, sdo;
    enter_load();
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), sdo);
    send_byte(8'h5A, sdo);
    checks++;
    if (ld_full !== 1'b1) begin
      failures++;
      $display("FAIL wrap_full got=%b exp=1", ld_full);
    end
    exit_load();
    read_word(4'd0, d);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL wrap_word0 got=%h exp=5a", d); end
    read_word(4'd1, d);
    checks++;
    if (d !== 8'h11) begin failures++; $display("FAIL wrap_word1 got=%h exp=11", d); end
    read_word(4'd15, d);
    checks++;
    if (d !== 8'h1F) begin failures++; $display("FAIL wrap_word15 got=%h exp=1f", d); end
  endtask

  task automatic test_partial();
    logic [7:0] d, sdo;
    logic s;
    enter_load();
    send_byte(8'h3C, sdo);
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s);
    send_bit(1'b1, s); send_bit(1'b0, s);
    exit_load();
    read_word(4'd0, d);
    checks++;
    if (d !== 8'h3C) begin failures++; $display("FAIL partial_word0 got=%h exp=3c", d); end
    read_word(4'd1, d);
    checks++;
    if (d !== 8'h11) begin failures++; $display("FAIL partial_word1 got=%h exp=11", d); end
    checks++;
    if (ld_full !== 1'b0) begin failures++; $display("FAIL partial_full got=%b exp=0", ld_full); end
    // A fresh load must start on a byte boundary at word 0.
    enter_load();
    send_byte(8'h96, sdo);
    exit_load();
    read_word(4'd0, d);
    checks++;
    if (d !== 8'h96) begin failures++; $display("FAIL reload_word0 got=%h exp=96", d); end
    read_word(4'd1, d);
    checks++;
    if (d !== 8'h11) begin failures++; $display("FAIL reload_word1 got=%h exp=11", d); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] d;
    logic s;
    enter_load();
    send_bit(1'b1, s); send_bit(1'b1, s); send_bit(1'b0, s);
    rst_n = 1'b0;
    ld_en = 1'b0;
    tick(1);
    checks++;
    if (cpu_n_reset !== 1'b1) begin
      failures++;
      $display("FAIL midreset_cpu_n_reset got=%b exp=1", cpu_n_reset);
    end
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL midreset_word addr=%0d got=%h exp=00", a, d);
      end
    end
    rst_n = 1'b1;
    tick(1);
    // Short glitches, then full-speed pulses, with the FSM in RUN.
    ld_sdata = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #3 ld_sclk = 1'b1;
      #3 ld_sclk = 1'b0;
    end
    tick(1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, s);
    tick(SYNC + 2);
    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), d);
      checks++;
      if (d !== 8'h00 || cpu_n_reset !== 1'b1 || ld_full !== 1'b0) begin
        failures++;
        $display("FAIL run_ignore addr=%0d instr=%h rst=%b full=%b exp=00/1/0",
                 a, d, cpu_n_reset, ld_full);
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] d, sdo, exp_sdo;
`ifdef PROG_LOADER_READBACK_EN
    exp_sdo = 8'hA5;
`else
    exp_sdo = 8'h00;
`endif
    enter_load();
    send_byte(8'hA5, sdo);
    exit_load();
    enter_load();
    send_byte(8'h00, sdo);
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (sdo[i] !== exp_sdo[i]) begin
        failures++;
        $display("FAIL readback_bit%0d got=%b exp=%b", i, sdo[i], exp_sdo[i]);
      end
    end
    exit_load();
    read_word(4'd0, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL readback_word0 got=%h exp=00", d); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_full_load();
    test_overwrite();
    test_partial();
    test_reset_mid_load();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serially loaded 16 x 8 instruction store that sits directly upstream of the 4-bit CPU core. In RUN it returns the instruction for the CPU's program-counter address combinationally, so the CPU's one-instruction-per-clock behaviour is preserved. In LOAD it holds the CPU in reset and accepts program bytes over a slow three-pin serial interface driven from the input switches or an external MCU.

## Interface
- `DEPTH`, 16: number of instruction words; must equal 2**`ADDR_W`.
- `ADDR_W`, 4: CPU address width.
- `SYNC_STAGES`, 2: synchronizer flops on each serial pin (≥2).
- `clk` in 1: single clock for all state.
- `rst_n` in 1: reset, synchronous, active-low.
- `ld_en` in 1: asynchronous pin; high requests LOAD mode.
- `ld_sclk` in 1: asynchronous serial clock pin; data sampled on its rising edge.
- `ld_sdata` in 1: asynchronous serial data pin, MSB first.
- `address` in `ADDR_W`: CPU program counter.
- `instr` out 8: instruction to the CPU.
- `cpu_n_reset` out 1: active-low reset to the CPU.
- `ld_full` out 1: all `DEPTH` words written since LOAD was entered.
- `ld_sdo` out 1: readback serial data (see Configuration).

## Operation
- All three serial pins pass through `SYNC_STAGES` flops. `ld_sclk` additionally feeds one edge-detect flop; `sclk_rise` is a one-cycle pulse.
- FSM states:
  - RUN: `cpu_n_reset`=1.
  - LOAD: `cpu_n_reset`=0.
  - RELEASE: `cpu_n_reset`=0, lasts exactly 1 cycle.
- FSM transitions:
  - RUN→LOAD when synced `ld_en`=1. On entry, clear `wr_ptr`, `bit_cnt` and `ld_full`.
  - LOAD→RELEASE when synced `ld_en`=0.
  - RELEASE→RUN unconditionally.
  - If `ld_en` reasserts during RELEASE, the FSM still goes to RUN first, then to LOAD on the next cycle.
- In LOAD, each `sclk_rise` shifts synced `ld_sdata` into `shift[0]`; `bit_cnt` increments mod 8.
- When the 8th bit is shifted, the byte {shift[6:0], bit} is written to `mem[wr_ptr]` in the same cycle and `wr_ptr` increments mod `DEPTH`.
- `ld_full` sets when `wr_ptr` wraps 15→0 and stays set until the next LOAD entry. A 17th byte overwrites word 0.
- A partial byte left at LOAD exit is discarded. `bit_cnt` is cleared and memory is unchanged.
- `sclk_rise` outside LOAD is ignored.
- `instr` = `mem[address]` combinationally in RUN; 8'h00 in LOAD and RELEASE.
- There is no write/read bypass; the CPU is held in reset while writes occur.
- Reset values:
  - FSM in RUN, `cpu_n_reset`=1.
  - All `mem` words = 8'h00, so the CPU executes a harmless loop of the 8'h00 opcode.
  - `wr_ptr`=0, `bit_cnt`=0, `ld_full`=0, `ld_sdo`=0, synchronizers=0.
- Reset asserted mid-LOAD aborts the load: memory is cleared and the FSM returns to RUN.

## Timing
- Pin→`sclk_rise` latency is `SYNC_STAGES`+1 cycles.
- `ld_sclk` high and low phases must each be ≥ `SYNC_STAGES`+2 cycles.
- `ld_sdata` must be stable from ≥1 cycle before the `ld_sclk` rise until ≥ `SYNC_STAGES`+2 cycles after it.
- Memory write happens in the `sclk_rise` cycle; the word is visible on `instr` once in RUN.
- `ld_en` falling at the pin → `cpu_n_reset` rises `SYNC_STAGES`+2 cycles later (LOAD, RELEASE, RUN). The CPU fetches address 0 on the first RUN cycle.
- `instr` is purely combinational from `address`, with zero latency.

## Configuration
- Macro `PROG_LOADER_READBACK_EN` defined:
  - In LOAD, when `bit_cnt`=0 and `sclk_rise` is not active, `tx_shift` loads `mem[wr_ptr]`.
  - Each `sclk_rise` shifts `tx_shift` left.
  - `ld_sdo` = `tx_shift[7]`, so the old contents of each word stream out while the new word streams in.
- Macro undefined: `ld_sdo` is tied 0 and no `tx_shift` flops are built.

## Structure
- Shared package `prog_loader_pkg` holds:
  - The FSM state enum: RUN=2'd0, LOAD=2'd1, RELEASE=2'd2.
  - `NOP_INSTR` = 8'h00.
  - Default `DEPTH`/`ADDR_W`.
- One sub-module, `pin_sync`: a `SYNC_STAGES`-deep synchronizer with an optional rise-pulse output. It is instantiated three times; only the `ld_sclk` instance uses the rise pulse.

## Test plan
- Reset, then RUN with `address` sweeping 0..15 → `instr`=8'h00 every address, `cpu_n_reset`=1, `ld_full`=0.
- LOAD and shift 16 bytes 8'hB7, 8'h01, 8'hE1, ... 8'hFF, then drop `ld_en` → `ld_full`=1; `cpu_n_reset` low throughout, high `SYNC_STAGES`+2 cycles after the drop; `instr` at `address`=0 is 8'hB7 and at 15 is 8'hFF.
- LOAD 17 bytes, the 17th = 8'h5A → word 0 = 8'h5A, word 1 keeps the 2nd byte, `ld_full`=1.
- LOAD 1 full byte 8'h3C plus 5 bits, then exit → word 0 = 8'h3C, word 1 unchanged; a new LOAD begins at `wr_ptr`=0.
- `rst_n` low mid-byte during LOAD → next cycle all `mem` reads 8'h00, FSM in RUN, `cpu_n_reset`=1; glitches on `ld_sclk` shorter than 1 cycle outside LOAD cause no writes.
- With `PROG_LOADER_READBACK_EN`: after loading word 0 = 8'hA5, re-enter LOAD and shift 8'h00 → `ld_sdo` emits 1,0,1,0,0,1,0,1; without the macro, `ld_sdo` stays 0.
